hit_pulse_gen: RTL and testbench
================================

# hit_pulse_gen

Programmable hit-pulse generator for TDC self-test and calibration: on a start request it drives a train of N rectangular pulses with configurable high and low lengths (in clock cycles) onto a hit line. It sits on the stimulus side of the edge-detector path and drives the same hit input the detector samples. Cycle-aligned rise/fall strobes give the bench and the calibration logic a golden reference to compare against detector output.

## Interface

Parameters:
- W, 16, width of the high/low length inputs and internal phase counter
- NW, 16, width of the pulse-count input and internal pulse counter

Ports:
- iClk  in  1  system clock; all logic on rising edge
- iRst  in  1  asynchronous, active-high reset
- iStart  in  1  start request; sampled only in IDLE
- iHighCycles  in  W  pulse high length in cycles; 0 treated as 1
- iLowCycles  in  W  gap length in cycles; 0 treated as 1
- iCount  in  NW  number of pulses; 0 = empty train
- oHit  out  1  generated hit line, registered
- oRiseStb  out  1  one-cycle strobe, high in the first cycle oHit is 1
- oFallStb  out  1  one-cycle strobe, high in the first cycle oHit is 0 after a pulse
- oBusy  out  1  high while a train is in progress (HIGH or LOW state)
- oDone  out  1  one-cycle strobe at end of train

## Operation

- FSM states: IDLE, HIGH, LOW, DONE. All outputs are registered.
- IDLE: if iStart=1, latch iHighCycles, iLowCycles and iCount, applying the zero→1 rule to both lengths. If the latched count is 0, go to DONE. Otherwise go to HIGH, load the phase counter with H and the pulse counter with N.
- HIGH: oHit=1, oBusy=1. The phase counter decrements each cycle. After H cycles go to LOW, load the phase counter with L, and decrement the pulse counter.
- LOW: oHit=0, oBusy=1. After L cycles: if pulses remain, go to HIGH; otherwise go to DONE.
- DONE: lasts exactly 1 cycle with oDone=1 and oBusy=0, then goes to IDLE.
- Strobes:
  - oRiseStb=1 only on the first cycle of each HIGH phase.
  - oFallStb=1 only on the first cycle of each LOW phase.
  - Exactly N of each per train.
- The last pulse is always followed by a full L-cycle low gap before DONE, so a downstream 2-FF detector sees every fall.
- iStart is ignored in HIGH, LOW and DONE; latched parameters do not change mid-train.
- Input changes outside the IDLE sampling cycle have no effect.
- Counters never wrap: H, L ≤ 2^W−1 and N ≤ 2^NW−1 are valid at maximum values.

## Timing

- Reset (asynchronous, immediate): state IDLE; oHit, oRiseStb, oFallStb, oBusy, oDone all 0; counters 0. Reset mid-train drops oHit immediately, with no fall strobe and no done strobe.
- Start latency: iStart sampled high in IDLE at edge T:
  - oHit=1, oRiseStb=1, oBusy=1 from edge T+1.
  - oHit high for cycles T+1 … T+H.
  - oHit=0 and oFallStb=1 at T+H+1.
  - Next rise at T+H+L+1; pulse period is exactly H+L cycles.
- End of train: oDone=1 at T+N·(H+L)+1 for one cycle, oBusy=0 in that cycle. The earliest cycle a new iStart is accepted is the following IDLE cycle, T+N·(H+L)+2.
- N=0: oDone=1 at T+1; oHit, oBusy and the strobes stay 0.
- iStart held high continuously: trains repeat back-to-back, with 2 cycles between the last gap's end and the next rise (DONE, then IDLE sampling).

## Configuration

- HIT_GEN_ABORT_EN defined:
  - Adds input iAbort (1 bit).
  - iAbort=1 in HIGH or LOW moves the FSM to DONE at the next edge: oHit=0 and oDone=1 that cycle. If aborted in HIGH, oFallStb=1 in that same cycle.
  - Abort has priority over normal phase transitions.
  - iAbort is ignored in IDLE and DONE.
- Not defined: the iAbort port does not exist; a train always runs to completion or until reset.

## Test plan

- Basic pulse: H=3, L=2, N=1, start at T → oHit=1 on T+1..T+3, 0 from T+4; oRiseStb at T+1; oFallStb at T+4; oDone at T+6; oBusy=1 for T+1..T+5.
- Train: H=1, L=1, N=4 → oHit toggles 1,0,1,0,1,0,1,0 from T+1; 4 rise and 4 fall strobes; oDone at T+9.
- Zero handling: H=0, L=0, N=2 behaves as H=1, L=1 (oDone at T+5). Separately, N=0 → oDone at T+1 and oHit never asserts.
- Mid-train restart and reset: H=5, L=5, N=3; pulse iStart at T+4 → ignored, train unchanged. Assert iRst at T+7 → oHit and oBusy drop immediately with no oDone. After release, a new start gives a rise 1 cycle later.
- Maximum values: H=L=2^W−1, N=2 → measured high and low lengths exactly 65535 cycles each (W=16), no counter wrap, oDone at T+4·65535+1.
- With HIT_GEN_ABORT_EN: H=4, L=4, N=10; iAbort at T+2 → at T+3 oHit=0, oFallStb=1, oDone=1; IDLE at T+4.

Source files
------------

// File: rtl/hit_pulse_gen.sv
// hit_pulse_gen: programmable hit-pulse train generator with cycle-aligned rise/fall/done strobes.
// Optional macro HIT_GEN_ABORT_EN adds iAbort, which cuts a running train short into DONE.
module hit_pulse_gen #(
  parameter int unsigned W  = 16,
  parameter int unsigned NW = 16
) (
  input  logic          iClk,
  input  logic          iRst,
`ifdef HIT_GEN_ABORT_EN
  input  logic          iAbort,
`endif
  input  logic          iStart,
  input  logic [W-1:0]  iHighCycles,
  input  logic [W-1:0]  iLowCycles,
  input  logic [NW-1:0] iCount,
  output logic          oHit,
  output logic          oRiseStb,
  output logic          oFallStb,
  output logic          oBusy,
  output logic          oDone
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  high_len, high_len_nxt;
  logic [W-1:0]  low_len, low_len_nxt;
  logic [W-1:0]  phase, phase_nxt;
  logic [NW-1:0] pulses, pulses_nxt;
  logic [W-1:0]  start_high, start_low;
  logic          abort;
  logic          hit_nxt, rise_nxt, fall_nxt, busy_nxt, done_nxt;

`ifdef HIT_GEN_ABORT_EN
  assign abort = iAbort;
`else
  assign abort = 1'b0;
`endif

  assign start_high = (iHighCycles == '0) ? W'(1) : iHighCycles;
  assign start_low  = (iLowCycles  == '0) ? W'(1) : iLowCycles;

  always_comb begin
    state_nxt    = state;
    high_len_nxt = high_len;
    low_len_nxt  = low_len;
    phase_nxt    = phase;
    pulses_nxt   = pulses;
    unique case (state)
      S_IDLE: begin
        if (iStart) begin
          high_len_nxt = start_high;
          low_len_nxt  = start_low;
          if (iCount == '0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt  = S_HIGH;
            phase_nxt  = start_high;
            pulses_nxt = iCount;
          end
        end
      end
      S_HIGH: begin
        if (abort) begin
          state_nxt = S_DONE;
        end else if (phase == W'(1)) begin
          state_nxt  = S_LOW;
          phase_nxt  = low_len;
          pulses_nxt = pulses - NW'(1);
        end else begin
          phase_nxt = phase - W'(1);
        end
      end
      S_LOW: begin
        if (abort) begin
          state_nxt = S_DONE;
        end else if (phase == W'(1)) begin
          if (pulses != '0) begin
            state_nxt = S_HIGH;
            phase_nxt = high_len;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          phase_nxt = phase - W'(1);
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so strobes mark phase entry;
  // HIGH->DONE only happens on abort and still counts as a fall.
  always_comb begin
    hit_nxt  = (state_nxt == S_HIGH);
    busy_nxt = (state_nxt == S_HIGH) || (state_nxt == S_LOW);
    done_nxt = (state_nxt == S_DONE);
    rise_nxt = (state_nxt == S_HIGH) && (state != S_HIGH);
    fall_nxt = ((state_nxt == S_LOW) && (state != S_LOW)) ||
               ((state == S_HIGH) && (state_nxt == S_DONE));
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= S_IDLE;
      high_len <= '0;
      low_len  <= '0;
      phase    <= '0;
      pulses   <= '0;
      oHit     <= 1'b0;
      oRiseStb <= 1'b0;
      oFallStb <= 1'b0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
    end else begin
      state    <= state_nxt;
      high_len <= high_len_nxt;
      low_len  <= low_len_nxt;
      phase    <= phase_nxt;
      pulses   <= pulses_nxt;
      oHit     <= hit_nxt;
      oRiseStb <= rise_nxt;
      oFallStb <= fall_nxt;
      oBusy    <= busy_nxt;
      oDone    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_hit_pulse_gen.sv
// Self-checking bench for hit_pulse_gen: timeline model of the pulse train plus directed literal checks.
// Abort scenarios are exercised only when HIT_GEN_ABORT_EN is defined.
module tb_hit_pulse_gen;

  localparam int TW   = 10;
  localparam int TMAX = (1 << TW) - 1;

  logic          iClk = 1'b0;
  logic          iRst = 1'b1;
  logic          iAbort = 1'b0;
  logic          iStart = 1'b0;
  logic [TW-1:0] iHighCycles = '0;
  logic [TW-1:0] iLowCycles = '0;
  logic [15:0]   iCount = '0;
  logic          oHit, oRiseStb, oFallStb, oBusy, oDone;

  hit_pulse_gen #(.W(TW), .NW(16)) dut (
    .iClk        (iClk),
    .iRst        (iRst),
`ifdef HIT_GEN_ABORT_EN
    .iAbort      (iAbort),
`endif
    .iStart      (iStart),
    .iHighCycles (iHighCycles),
    .iLowCycles  (iLowCycles),
    .iCount      (iCount),
    .oHit        (oHit),
    .oRiseStb    (oRiseStb),
    .oFallStb    (oFallStb),
    .oBusy       (oBusy),
    .oDone       (oDone)
  );

  always #5 iClk = ~iClk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  function automatic void chk_bit(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endfunction

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Model: a train is a timeline; cycle k after the start edge is high when
  // k mod (H+L) < H, and the train ends after N*(H+L) cycles.
  typedef enum {M_IDLE, M_TRAIN, M_DONE} mmode_t;
  mmode_t m_mode = M_IDLE;
  int mh = 1, ml = 1, mn = 0, mk = 0, w = 0;
  bit ab_fall = 0;
  logic e_hit = 0, e_rise = 0, e_fall = 0, e_busy = 0, e_done = 0;

  always @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      m_mode = M_IDLE;
      {e_hit, e_rise, e_fall, e_busy, e_done} = '0;
    end else begin
      ab_fall = 0;
      case (m_mode)
        M_IDLE: if (iStart) begin
          mh = (iHighCycles == 0) ? 1 : int'(iHighCycles);
          ml = (iLowCycles == 0) ? 1 : int'(iLowCycles);
          mn = int'(iCount);
          mk = 0;
          m_mode = (mn == 0) ? M_DONE : M_TRAIN;
        end
        M_TRAIN: if (iAbort) begin
          ab_fall = (mk % (mh + ml)) < mh;
          m_mode = M_DONE;
        end else begin
          mk++;
          if (mk == mn * (mh + ml)) m_mode = M_DONE;
        end
        default: m_mode = M_IDLE;
      endcase
      {e_hit, e_rise, e_fall, e_busy, e_done} = '0;
      if (m_mode == M_TRAIN) begin
        w = mk % (mh + ml);
        e_hit  = (w < mh);
        e_rise = (w == 0);
        e_fall = (w == mh);
        e_busy = 1;
      end else if (m_mode == M_DONE) begin
        e_done = 1;
        e_fall = ab_fall;
      end
    end
  end

  int rise_n, fall_n, done_n, hit_n, busy_n;
  int first_rise, first_fall, last_rise, last_done;

  always @(negedge iClk) begin
    chk_bit("hit", oHit, e_hit);
    chk_bit("rise_stb", oRiseStb, e_rise);
    chk_bit("fall_stb", oFallStb, e_fall);
    chk_bit("busy", oBusy, e_busy);
    chk_bit("done", oDone, e_done);
    if (oRiseStb === 1'b1) begin
      rise_n++; last_rise = cyc;
      if (first_rise < 0) first_rise = cyc;
    end
    if (oFallStb === 1'b1) begin
      fall_n++;
      if (first_fall < 0) first_fall = cyc;
    end
    if (oDone === 1'b1) begin done_n++; last_done = cyc; end
    if (oHit === 1'b1) hit_n++;
    if (oBusy === 1'b1) busy_n++;
  end

  task automatic tick();
    @(negedge iClk);
    #1;
  endtask

  task automatic clear_logs();
    rise_n = 0; fall_n = 0; done_n = 0; hit_n = 0; busy_n = 0;
    first_rise = -1; first_fall = -1; last_rise = -1; last_done = -1;
  endtask

  task automatic start_train(input int h, input int l, input int n, output int t0);
    iHighCycles = TW'(h);
    iLowCycles  = TW'(l);
    iCount      = 16'(n);
    iStart      = 1'b1;
    t0 = cyc;
    clear_logs();
    tick();
    iStart = 1'b0;
    iHighCycles = TW'($urandom);
    iLowCycles  = TW'($urandom);
    iCount      = 16'($urandom);
  endtask

  task automatic wait_done(input string name, input int target, input int limit);
    int n = 0;
    while (done_n < target && n < limit) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, (done_n >= target) ? 1 : 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int t0, t1;

  initial begin
    clear_logs();
    tick(); tick();
    iRst = 1'b0;
    chk_bit("reset_hit", oHit, 1'b0);
    chk_bit("reset_busy", oBusy, 1'b0);
    chk_bit("reset_done", oDone, 1'b0);
    tick();

    // Basic single pulse
    start_train(3, 2, 1, t0);
    wait_done("basic", 1, 40);
    check("basic_rise_cyc", first_rise, t0 + 1);
    check("basic_fall_cyc", first_fall, t0 + 4);
    check("basic_done_cyc", last_done, t0 + 6);
    check("basic_hit_len", hit_n, 3);
    check("basic_busy_len", busy_n, 5);
    tick(); tick();

    // Tight train
    start_train(1, 1, 4, t0);
    wait_done("train", 1, 40);
    check("train_rises", rise_n, 4);
    check("train_falls", fall_n, 4);
    check("train_hit_len", hit_n, 4);
    check("train_done_cyc", last_done, t0 + 9);
    tick();

    // Zero lengths behave as 1
    start_train(0, 0, 2, t0);
    wait_done("zero_len", 1, 40);
    check("zero_len_done_cyc", last_done, t0 + 5);
    check("zero_len_rises", rise_n, 2);
    tick();

    // Empty train
    start_train(5, 5, 0, t0);
    wait_done("empty", 1, 10);
    check("empty_done_cyc", last_done, t0 + 1);
    check("empty_hit_len", hit_n, 0);
    check("empty_busy_len", busy_n, 0);
    tick();

    // Restart ignored mid-train, then asynchronous reset
    start_train(5, 5, 3, t0);
    tick(); tick(); tick();
    iHighCycles = TW'(1); iLowCycles = TW'(1); iCount = 16'd1; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    tick(); tick();
    check("restart_cycle_is_t7", cyc, t0 + 7);
    chk_bit("pre_reset_busy", oBusy, 1'b1);
    check("restart_ignored_fall", first_fall, t0 + 6);
    iRst = 1'b1;
    #1;
    chk_bit("async_reset_hit", oHit, 1'b0);
    chk_bit("async_reset_busy", oBusy, 1'b0);
    chk_bit("async_reset_fall", oFallStb, 1'b0);
    tick();
    iRst = 1'b0;
    tick(); tick(); tick();
    check("reset_no_done", done_n, 0);
    check("reset_rises", rise_n, 1);
    start_train(2, 2, 1, t1);
    wait_done("post_reset", 1, 20);
    check("post_reset_rise_cyc", first_rise, t1 + 1);
    tick();

    // All-ones lengths
    start_train(TMAX, TMAX, 2, t0);
    wait_done("max", 1, 4 * TMAX + 20);
    check("max_fall_cyc", first_fall, t0 + TMAX + 1);
    check("max_hit_len", hit_n, 2 * TMAX);
    check("max_busy_len", busy_n, 4 * TMAX);
    check("max_done_cyc", last_done, t0 + 4 * TMAX + 1);
    tick();

    // iStart held high: back-to-back trains
    iHighCycles = TW'(2); iLowCycles = TW'(1); iCount = 16'd2; iStart = 1'b1;
    t0 = cyc;
    clear_logs();
    wait_done("b2b_first", 1, 30);
    check("b2b_first_done_cyc", last_done, t0 + 7);
    for (int n = 0; n < 20 && rise_n < 3; n++) tick();
    check("b2b_second_rise_cyc", last_rise, t0 + 9);
    iStart = 1'b0;
    wait_done("b2b_second", 2, 30);
    check("b2b_second_done_cyc", last_done, t0 + 15);
    tick();

`ifdef HIT_GEN_ABORT_EN
    // Abort during HIGH
    start_train(4, 4, 10, t0);
    tick();
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    chk_bit("abort_hi_hit", oHit, 1'b0);
    chk_bit("abort_hi_fall", oFallStb, 1'b1);
    chk_bit("abort_hi_done", oDone, 1'b1);
    check("abort_hi_done_cyc", last_done, t0 + 3);
    tick();
    chk_bit("abort_hi_idle_busy", oBusy, 1'b0);
    chk_bit("abort_hi_idle_done", oDone, 1'b0);
    tick();

    // Abort during LOW: no extra fall
    start_train(2, 3, 5, t0);
    tick(); tick(); tick();
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    check("abort_lo_done_cyc", last_done, t0 + 5);
    check("abort_lo_falls", fall_n, 1);
    tick(); tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
